// File: rtl/gpu_mixer_if.sv
// CPU register bus between the mapache64 VRAM-side CPU and the mixer.
`timescale 1ns/1ps

interface gpu_mixer_if;
  // Strobes are plain levels sampled on every gpu_clk edge; there is no
  // valid/ready pair. A write happens on each edge where write_enable and a
  // select are high, and data_out is valid combinationally while a select is held.
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       write_enable;
  logic       SELECT_layer_en;
  logic       SELECT_status;
  logic       SELECT_frame;
  logic       SELECT_clr_vblank_irq;
  logic       vblank_irq;

  modport master (
    output data_in, write_enable, SELECT_layer_en, SELECT_status,
           SELECT_frame, SELECT_clr_vblank_irq,
    input  data_out, vblank_irq
  );

  modport slave (
    input  data_in, write_enable, SELECT_layer_en, SELECT_status,
           SELECT_frame, SELECT_clr_vblank_irq,
    output data_out, vblank_irq
  );
endinterface

// File: rtl/gpu_mixer.sv
// Raster timing, fixed-priority layer compositing, vblank interrupt and
// frame counter for the mapache64 GPU.
`timescale 1ns/1ps

module gpu_mixer #(
  parameter int COLOR_BITS     = 2,
  parameter int NUM_LAYERS     = 3,
  parameter int H_TOTAL        = 800,
  parameter int H_SYNC_START   = 656,
  parameter int H_SYNC_END     = 752,
  parameter int V_TOTAL        = 525,
  parameter int V_ACTIVE       = 480,
  parameter int V_SYNC_START   = 490,
  parameter int V_SYNC_END     = 492,
  parameter int X_OFFSET       = 32,
  parameter int WIN_W          = 256,
  parameter int WIN_H          = 240,
  parameter int LINE_REPEAT    = 2,
  parameter int IRQ_BOTH_EDGES = 0,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL),
  localparam int LB = 3 * COLOR_BITS
) (
  input  logic                     gpu_clk,
  input  logic                     rst,
  input  logic [NUM_LAYERS*LB-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]    layer_valid,
  output logic [HW-1:0]            hcounter,
  output logic [VW-1:0]            vcounter,
  output logic [HW-1:0]            current_x,
  output logic [HW-1:0]            next_x,
  output logic [VW-1:0]            current_y,
  output logic [VW-1:0]            next_y,
  output logic [COLOR_BITS-1:0]    r,
  output logic [COLOR_BITS-1:0]    g,
  output logic [COLOR_BITS-1:0]    b,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     in_vblank,
  output logic                     controller_start_fetch,
  gpu_mixer_if.slave               bus
);

  localparam int LR_SHIFT = $clog2(LINE_REPEAT);
  localparam int Y_LAST   = (V_TOTAL - 1) / LINE_REPEAT;

  logic [NUM_LAYERS-1:0] en;
  logic [7:0]            frame;
  logic                  line_end;
  logic                  frame_end;
  logic                  drawing;
  logic                  irq_set;
  logic                  irq_clr;
  logic                  found;
  logic [LB-1:0]         pix;

  // The backdrop's valid bit never matters and the upper bus bits are unused.
  logic [7:0] unused_data;
  logic       unused_backdrop_valid;
  assign unused_data           = bus.data_in;
  assign unused_backdrop_valid = layer_valid[NUM_LAYERS-1];

  assign line_end  = (hcounter == HW'(H_TOTAL - 1));
  assign frame_end = (vcounter == VW'(V_TOTAL - 1));

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      hcounter <= '0;
      vcounter <= '0;
    end else if (line_end) begin
      hcounter <= '0;
      vcounter <= frame_end ? '0 : vcounter + VW'(1);
    end else begin
      hcounter <= hcounter + HW'(1);
    end
  end

  assign current_x = hcounter - HW'(X_OFFSET);
  assign next_x    = current_x + HW'(1);
  assign current_y = vcounter >> LR_SHIFT;
  assign next_y    = (current_y == VW'(Y_LAST)) ? '0 : current_y + VW'(1);

  assign in_vblank              = (32'(vcounter) >= V_ACTIVE);
  assign controller_start_fetch = (32'(hcounter) < 32'd32) && (vcounter == '0);

  assign drawing = (32'(hcounter) < H_SYNC_START) && (32'(vcounter) < V_ACTIVE) &&
                   (32'(current_x) < WIN_W) && (32'(current_y) < WIN_H);

  // Front layers need an opaque pixel; the backdrop fills whenever enabled.
  always_comb begin
    pix   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_LAYERS - 1; i++) begin
      if (!found && layer_valid[i] && en[i]) begin
        pix   = layer_rgb[i*LB +: LB];
        found = 1'b1;
      end
    end
    if (!found && en[NUM_LAYERS-1]) pix = layer_rgb[(NUM_LAYERS-1)*LB +: LB];
    if (!drawing) pix = '0;
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      {r, g, b} <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else begin
      {r, g, b} <= pix;
      hsync     <= !((32'(hcounter) >= H_SYNC_START) && (32'(hcounter) < H_SYNC_END));
      vsync     <= !((32'(vcounter) >= V_SYNC_START) && (32'(vcounter) < V_SYNC_END));
    end
  end

  // Raise on the transition into vblank (and optionally out of it), never on reset.
  assign irq_set = line_end && ((32'(vcounter) == V_ACTIVE - 1) ||
                                ((IRQ_BOTH_EDGES != 0) && frame_end));
  assign irq_clr = bus.write_enable && bus.SELECT_clr_vblank_irq;

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      en             <= '1;
      frame          <= 8'h00;
      bus.vblank_irq <= 1'b0;
    end else begin
      if (bus.write_enable && bus.SELECT_layer_en) en <= bus.data_in[NUM_LAYERS-1:0];
      if (line_end && frame_end) frame <= frame + 8'd1;
      if (irq_set)      bus.vblank_irq <= 1'b1;
      else if (irq_clr) bus.vblank_irq <= 1'b0;
    end
  end

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.SELECT_status)        bus.data_out = {6'b0, bus.vblank_irq, in_vblank};
    else if (bus.SELECT_layer_en) bus.data_out = 8'(en);
    else if (bus.SELECT_frame)    bus.data_out = frame;
  end

endmodule
